// File: rtl/serial_pkg.sv
// Shared definitions for the parity serial link (receiver FSM states, line levels, parity check).
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;

   // Narrower words are zero-extended, which leaves the XOR reduction unchanged.
   function automatic logic parity_ok(input logic [31:0] data, input logic pbit, input logic odd);
      return ((^{data, pbit}) == odd);
   endfunction

endpackage

// File: rtl/serial_parity_rx_if.sv
// Received-word bus: word plus per-word flags, valid/ready handshake.
interface serial_parity_rx_if #(parameter int DATA_W = 8) ();

   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready;
   logic              parity_err;
   logic              frame_err;

   modport master (
      output data_out, data_valid, parity_err, frame_err,
      input  data_ready
   );

   modport slave (
      input  data_out, data_valid, parity_err, frame_err,
      output data_ready
   );

endinterface

// File: rtl/serial_parity_rx_hold_reg.sv
// Holding register for received words; loads on the clock edge that completes a frame.
// A completion while full and not handshaking drops the frame and sets sticky overrun.
// Reset is synchronous and active-low.
module rx_hold_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_vld,
   input  logic [DATA_W-1:0] load_dat,
   input  logic              load_perr,
   input  logic              load_ferr,
   serial_parity_rx_if.master rx,
   output logic              overrun
);

   logic take;

   assign take = rx.data_valid & rx.data_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx.data_out   <= '0;
         rx.data_valid <= 1'b0;
         rx.parity_err <= 1'b0;
         rx.frame_err  <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         // A same-cycle handshake frees the slot, so the new word replaces the old.
         if (load_vld && (!rx.data_valid || take)) begin
            rx.data_out   <= load_dat;
            rx.data_valid <= 1'b1;
            rx.parity_err <= load_perr;
            rx.frame_err  <= load_ferr;
         end else if (load_vld) begin
            overrun <= 1'b1;
         end else if (take) begin
            rx.data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver (start/data/[parity]/stop, LSB first); parity stage present with SERIAL_RX_PARITY_EN.
// Word is valid 1 clk after the strobe that samples the stop bit; line has no backpressure,
// so a frame completing against a full, unaccepted holding register is dropped and flagged as overrun.
module serial_parity_rx
   import serial_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_en,
   input  logic sdata,
   serial_parity_rx_if.master rx,
   output logic overrun,
   output logic busy
);

   localparam int                CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

   rx_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;
   logic              done;
   logic              perr;
   logic              ferr;

`ifdef SERIAL_RX_PARITY_EN
   logic pbit;

   always_ff @(posedge clk) begin
      if (!rst_n)
         pbit <= 1'b0;
      else if (sample_en && state == PARITY)
         pbit <= sdata;
   end

   assign perr = ~parity_ok(32'(shreg), pbit, PARITY_ODD != 0);
`else
   logic unused_parity_cfg;

   assign unused_parity_cfg = (PARITY_ODD != 0);
   assign perr              = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
         busy  <= 1'b0;
      end else if (sample_en) begin
         case (state)
            IDLE: begin
               if (sdata == START_LVL) begin
                  state <= DATA;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            DATA: begin
               // LSB arrives first, so each new bit enters at the top and walks down.
               shreg <= (shreg >> 1) | (DATA_W'(sdata) << (DATA_W - 1));
               if (cnt == LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                  state <= PARITY;
`else
                  state <= STOP;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PARITY: state <= STOP;
            STOP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign done = sample_en && (state == STOP);
   assign ferr = (sdata != IDLE_LVL);

   rx_hold_reg #(.DATA_W(DATA_W)) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_vld  (done),
      .load_dat  (shreg),
      .load_perr (perr),
      .load_ferr (ferr),
      .rx        (rx),
      .overrun   (overrun)
   );

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: frame-level reference model, vector table and corner sequences.
module tb_serial_parity_rx;
   import serial_pkg::*;

   localparam int W   = 8;
   localparam int ODD = 0;
`ifdef SERIAL_RX_PARITY_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif
   localparam int NBITS = W + 2 + (PEN ? 1 : 0);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sample_en = 1'b0;
   logic sdata = 1'b1;
   logic overrun;
   logic busy;

   serial_parity_rx_if #(.DATA_W(W)) rx_if ();

   always #5 clk = ~clk;

   serial_parity_rx #(.DATA_W(W), .PARITY_ODD(ODD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .sdata     (sdata),
      .rx        (rx_if.master),
      .overrun   (overrun),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;
   int busy_cnt = 0;
   int rdy_mode = 0;

   bit         m_valid, m_perr, m_ferr, m_ovr, m_busy;
   logic [W-1:0] m_data;

   typedef struct {
      logic [W-1:0] d;
      bit           p;
      bit           stop;
      logic [W-1:0] exp_data;
      bit           exp_perr;
      bit           exp_ferr;
   } vec_t;

   vec_t tv[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_perr(input logic [W-1:0] d, input bit p);
      if (!PEN) return 1'b0;
      return ((($countones(d) + int'(p)) % 2) != ODD);
   endfunction

   function automatic bit get_rdy();
      if (rdy_mode == 0) return 1'b0;
      if (rdy_mode == 1) return 1'b1;
      return bit'($urandom_range(0, 1));
   endfunction

   task automatic compare_all();
      chk("data_valid", rx_if.data_valid, m_valid);
      chk("data_out", rx_if.data_out, m_data);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, m_busy);
      if (m_valid) begin
         chk("parity_err", rx_if.parity_err, m_perr);
         chk("frame_err", rx_if.frame_err, m_ferr);
      end
   endtask

   // One clock: drive inputs, apply the frame-level rules at the edge, then compare.
   task automatic step(input bit se, input bit sd, input bit rdy, input bit rst, input bit done,
                       input bit busy_after, input logic [W-1:0] d, input bit pe, input bit fe);
      bit take;
      rst_n = ~rst;
      sample_en = se;
      sdata = sd;
      rx_if.data_ready = rdy;
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_data = '0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_busy = 0;
      end else begin
         take = m_valid && rdy;
         if (done) begin
            if (!m_valid || take) begin
               m_valid = 1; m_data = d; m_perr = pe; m_ferr = fe;
            end else begin
               m_ovr = 1;
            end
         end else if (take) begin
            m_valid = 0;
         end
         if (se) m_busy = busy_after;
      end
      #1;
      if (busy === 1'b1) busy_cnt++;
      compare_all();
   endtask

   task automatic do_reset();
      step(1'b0, IDLE_LVL, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(bit'($urandom_range(0, 1)), IDLE_LVL, get_rdy(), 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // rdy_stop < 0: data_ready follows rdy_mode on the stop strobe too.
   task automatic send_frame(input logic [W-1:0] d, input bit p, input bit stop, input int gap,
                             input int rdy_stop);
      bit bits[$];
      bit pe, fe, rdy;
      bits.push_back(START_LVL);
      for (int i = 0; i < W; i++) bits.push_back(d[i]);
      if (PEN) bits.push_back(p);
      bits.push_back(stop);
      pe = ref_perr(d, p);
      fe = !stop;
      for (int k = 0; k < bits.size(); k++) begin
         for (int g = 0; g < gap; g++)
            step(1'b0, bit'($urandom_range(0, 1)), get_rdy(), 1'b0, 1'b0, 1'b0, d, pe, fe);
         rdy = (k == bits.size() - 1 && rdy_stop >= 0) ? (rdy_stop != 0) : get_rdy();
         step(1'b1, bits[k], rdy, 1'b0, k == bits.size() - 1, k < bits.size() - 1, d, pe, fe);
      end
   endtask

   initial begin
      logic [W-1:0] v;
      rx_if.data_ready = 1'b0;

      do_reset();
      chk("rst_data_valid", rx_if.data_valid, 0);
      chk("rst_data_out", rx_if.data_out, 0);
      chk("rst_parity_err", rx_if.parity_err, 0);
      chk("rst_frame_err", rx_if.frame_err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);

      tv[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      tv[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
      tv[2] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1};
      tv[3] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};

      rdy_mode = 0;
      for (int i = 0; i < 4; i++) begin
         idle(2);
         send_frame(tv[i].d, tv[i].p, tv[i].stop, 0, -1);
         chk("vec_valid", rx_if.data_valid, 1);
         chk("vec_data", rx_if.data_out, tv[i].exp_data);
         chk("vec_perr", rx_if.parity_err, tv[i].exp_perr & PEN);
         chk("vec_ferr", rx_if.frame_err, tv[i].exp_ferr);
         step(1'b0, IDLE_LVL, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
         chk("vec_drop", rx_if.data_valid, 0);
      end

      // Strobe one cycle in four; random sdata between strobes must be ignored.
      do_reset();
      busy_cnt = 0;
      send_frame(8'hA5, 1'b0, 1'b1, 3, -1);
      chk("slow_data", rx_if.data_out, 8'hA5);
      chk("slow_perr", rx_if.parity_err, 0);
      chk("slow_ferr", rx_if.frame_err, 0);
      chk("slow_busy_cycles", busy_cnt, (NBITS - 1) * 4);

      // Back-to-back frames with no consumer: second is dropped.
      do_reset();
      send_frame(8'h3C, 1'b0, 1'b1, 0, -1);
      send_frame(8'hC3, 1'b0, 1'b1, 0, -1);
      chk("ovr_data", rx_if.data_out, 8'h3C);
      chk("ovr_flag", overrun, 1);
      step(1'b0, IDLE_LVL, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("ovr_drop_valid", rx_if.data_valid, 0);
      chk("ovr_sticky", overrun, 1);
      idle(3);
      chk("ovr_still_sticky", overrun, 1);

      // Handshake on the exact completion edge frees the slot.
      do_reset();
      send_frame(8'h3C, 1'b0, 1'b1, 0, -1);
      send_frame(8'hC3, 1'b0, 1'b1, 0, 1);
      chk("same_valid", rx_if.data_valid, 1);
      chk("same_data", rx_if.data_out, 8'hC3);
      chk("same_ovr", overrun, 0);

      // Reset after four data bits discards the partial frame.
      step(1'b1, START_LVL, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
      v = 8'h5A;
      for (int i = 0; i < 4; i++)
         step(1'b1, v[i], 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
      do_reset();
      chk("mid_rst_valid", rx_if.data_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", rx_if.data_out, 0);
      for (int i = 0; i < 6; i++)
         step(1'b1, IDLE_LVL, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("mid_rst_no_pulse", rx_if.data_valid, 0);
      send_frame(8'h5A, 1'b0, 1'b1, 0, -1);
      chk("post_rst_data", rx_if.data_out, 8'h5A);
      chk("post_rst_valid", rx_if.data_valid, 1);

      // Random frames, gaps, strobe spacing and consumer readiness.
      do_reset();
      rdy_mode = 2;
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 49) == 0) do_reset();
         idle($urandom_range(0, 3));
         send_frame(W'($urandom()), bit'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
                    $urandom_range(0, 3), -1);
      end
      rdy_mode = 1;
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
